// File: rtl/uart_pkg.sv
// UART receiver shared types: FSM states, parity and baud codes, oversample constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Oversample ticks per bit and the tick index at which a bit is sampled.
  localparam int OS        = 16;
  localparam int OS_W      = $clog2(OS);
  localparam int OS_SAMPLE = OS / 2 - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // 2'b11 is deliberately treated the same as no parity.
  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10,
    PAR_RSVD = 2'b11
  } par_t;

  typedef enum logic [1:0] {
    BD_1200 = 2'd0,
    BD_2400 = 2'd1,
    BD_4800 = 2'd2,
    BD_9600 = 2'd3
  } bd_t;

  // Frame configuration captured at the start edge.
  typedef struct packed {
    logic [1:0] bd_rate;
    logic       d_num;
    logic       s_num;
    logic [1:0] para;
  } cfg_t;

  function automatic logic par_enabled(input logic [1:0] p);
    return (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle: received byte, one-cycle valid strobe, error flags, busy.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must accept rx_valid when it pulses.
interface uart_rx_if;
  logic [7:0] out_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (output out_data, rx_valid, parity_err, frame_err, busy);
  modport slave  (input  out_data, rx_valid, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every CLK_DIV << (3 - bd_rate) clocks.
// Latency: first tick CLK_DIV << (3 - bd_rate) cycles after clr.
// Backpressure: none; free-running except for the synchronous clear.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_t,
  input  logic       r_t,
  input  logic       clr,
  input  logic [1:0] bd_rate,
  output logic       tick
);

  // Widest period is CLK_DIV << 3 (1200 baud).
  localparam int CW = $clog2(CLK_DIV * 8 + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] period_m1;
  logic [1:0]    shamt;

  assign shamt     = 2'(BD_9600) - bd_rate;
  assign period_m1 = (CW'(CLK_DIV) << shamt) - CW'(1);
  assign tick      = (cnt == period_m1);

  // Count up to period-1, then wrap; clr restarts the bit phase at a start edge.
  always_ff @(posedge clk_t or negedge r_t) begin
    if (!r_t) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/parity/stop recovery into a parallel byte.
// Latency: rx_valid 1 clk_t after the final stop-bit sample (3 clk_t after the line reaches it).
// Backpressure: none; each frame is presented once with a single-cycle rx_valid.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_t,
  input  logic       r_t,
  input  logic       in_data,
  input  logic [1:0] bd_rate,
  input  logic       d_num,
  input  logic       s_num,
  input  logic [1:0] para,
  uart_rx_if.master  rx
);

  logic            sync1;
  logic            rxs;
  logic            rxs_d;
  state_t          state;
  cfg_t            cfg;
  logic [OS_W-1:0] os_cnt;
  logic [2:0]      bit_cnt;
  logic            stop_cnt;
  logic [7:0]      shreg;
  logic            par_acc;
  logic            par_pend;
  logic            frm_pend;
  logic            tick;
  logic            sample;
  logic            start_edge;
  logic            last_bit;

  logic [7:0]      out_data_r;
  logic            rx_valid_r;
  logic            parity_err_r;
  logic            frame_err_r;
  logic            busy_r;

  assign rx.out_data   = out_data_r;
  assign rx.rx_valid   = rx_valid_r;
  assign rx.parity_err = parity_err_r;
  assign rx.frame_err  = frame_err_r;
  assign rx.busy       = busy_r;

  // Two-flop synchronizer plus one history flop for edge detection; idles high.
  always_ff @(posedge clk_t or negedge r_t) begin
    if (!r_t) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= in_data;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  // A start edge needs the previous synchronized sample high, so a held-low
  // line after a frame (break) never re-arms the receiver.
  assign start_edge = (state == ST_IDLE) && rxs_d && !rxs;
  assign sample     = tick && (os_cnt == OS_W'(OS_SAMPLE));
  assign last_bit   = (bit_cnt == (cfg.d_num ? 3'd7 : 3'd6));

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_t   (clk_t),
    .r_t     (r_t),
    .clr     (start_edge),
    .bd_rate (cfg.bd_rate),
    .tick    (tick)
  );

  // Oversample phase counter; runs only while a frame is in progress.
  always_ff @(posedge clk_t or negedge r_t) begin
    if (!r_t) begin
      os_cnt <= '0;
    end else if (start_edge) begin
      os_cnt <= '0;
    end else if ((state != ST_IDLE) && tick) begin
      os_cnt <= (os_cnt == OS_W'(OS - 1)) ? '0 : os_cnt + OS_W'(1);
    end
  end

  // Frame FSM with registered outputs; commit happens on the final stop sample.
  always_ff @(posedge clk_t or negedge r_t) begin
    if (!r_t) begin
      state        <= ST_IDLE;
      cfg          <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      par_pend     <= 1'b0;
      frm_pend     <= 1'b0;
      out_data_r   <= '0;
      rx_valid_r   <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            cfg      <= {bd_rate, d_num, s_num, para};
            shreg    <= '0;
            par_acc  <= 1'b0;
            par_pend <= 1'b0;
            frm_pend <= 1'b0;
            busy_r   <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (sample) begin
            if (rxs) begin
              busy_r <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              bit_cnt <= '0;
              state   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (sample) begin
            shreg[bit_cnt] <= rxs;
            par_acc        <= par_acc ^ rxs;
            bit_cnt        <= bit_cnt + 3'd1;
            if (last_bit) begin
              stop_cnt <= 1'b0;
              state    <= par_enabled(cfg.para) ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (sample) begin
            if ((par_acc ^ rxs) != (cfg.para == PAR_ODD)) begin
              par_pend <= 1'b1;
            end
            stop_cnt <= 1'b0;
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (sample) begin
            if (cfg.s_num && !stop_cnt) begin
              stop_cnt <= 1'b1;
              if (!rxs) begin
                frm_pend <= 1'b1;
              end
            end else begin
              out_data_r   <= {cfg.d_num & shreg[7], shreg[6:0]};
              parity_err_r <= par_pend;
              frame_err_r  <= frm_pend | ~rxs;
              rx_valid_r   <= 1'b1;
              busy_r       <= 1'b0;
              state        <= ST_IDLE;
            end
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_DIV = 4;

  logic       clk_t   = 1'b0;
  logic       r_t     = 1'b1;
  logic       in_data = 1'b1;
  logic [1:0] bd_rate = 2'd3;
  logic       d_num   = 1'b1;
  logic       s_num   = 1'b0;
  logic [1:0] para    = 2'b00;

  uart_rx_if rx_bus ();

  uart_rx #(.CLK_DIV(CLK_DIV)) dut (
    .clk_t   (clk_t),
    .r_t     (r_t),
    .in_data (in_data),
    .bd_rate (bd_rate),
    .d_num   (d_num),
    .s_num   (s_num),
    .para    (para),
    .rx      (rx_bus)
  );

  always #5 clk_t = ~clk_t;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_vld = 1'b0;
  int   busy_cnt = 0;
  int   busy_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int bit_cycles(input logic [1:0] bd);
    return OS * (CLK_DIV << (3 - int'(bd)));
  endfunction

  // Reference model: what a correct receiver reports for the frame actually driven.
  function automatic exp_t model(input logic [7:0] data, input logic dn, input logic [1:0] pa,
                                 input logic pbit, input logic st0, input logic st1, input logic sn);
    exp_t e;
    int   ones;
    e.data = dn ? data : {1'b0, data[6:0]};
    ones   = $countones(e.data) + int'(pbit);
    if (pa == 2'b10)      e.perr = (ones % 2) != 0;
    else if (pa == 2'b01) e.perr = (ones % 2) != 1;
    else                  e.perr = 1'b0;
    e.ferr = !st0 || (sn && !st1);
    return e;
  endfunction

  // Drive one frame; abort_bit >= 0 resets the DUT in the middle of that data bit.
  task automatic send_frame(input logic [7:0] data, input logic [1:0] bd, input logic dn,
                            input logic sn, input logic [1:0] pa, input logic flip_par,
                            input logic st0, input logic st1, input int gap_bits,
                            input logic scramble, input int abort_bit);
    int   bc;
    int   nb;
    int   ones;
    logic pbit;
    bc   = bit_cycles(bd);
    nb   = dn ? 8 : 7;
    ones = $countones(dn ? data : {1'b0, data[6:0]});
    pbit = ((pa == 2'b01) ? ~ones[0] : ones[0]) ^ flip_par;
    bd_rate = bd; d_num = dn; s_num = sn; para = pa;
    if (abort_bit < 0) exp_q.push_back(model(data, dn, pa, pbit, st0, st1, sn));
    in_data = 1'b0;
    repeat (bc) @(negedge clk_t);
    for (int i = 0; i < nb; i++) begin
      if (i == 0 && scramble) begin
        bd_rate = 2'($urandom); d_num = 1'($urandom); s_num = 1'($urandom); para = 2'($urandom);
      end
      in_data = data[i];
      repeat (bc / 2) @(negedge clk_t);
      if (i == 1) check("busy_mid_frame", {31'd0, rx_bus.busy}, 32'd1);
      if (i == abort_bit) begin
        r_t = 1'b0;
        #1;
        check("abort_out_data", {24'd0, rx_bus.out_data}, 32'd0);
        check("abort_rx_valid", {31'd0, rx_bus.rx_valid}, 32'd0);
        check("abort_parity_err", {31'd0, rx_bus.parity_err}, 32'd0);
        check("abort_frame_err", {31'd0, rx_bus.frame_err}, 32'd0);
        check("abort_busy", {31'd0, rx_bus.busy}, 32'd0);
        @(negedge clk_t);
        in_data = 1'b1;
        repeat (3) @(negedge clk_t);
        r_t = 1'b1;
        repeat (2 * bc) @(negedge clk_t);
        return;
      end
      repeat (bc - bc / 2) @(negedge clk_t);
    end
    if (par_enabled(pa)) begin
      in_data = pbit;
      repeat (bc) @(negedge clk_t);
    end
    in_data = st0;
    repeat (bc) @(negedge clk_t);
    if (sn) begin
      in_data = st1;
      repeat (bc) @(negedge clk_t);
    end
    in_data = 1'b1;
    repeat (gap_bits * bc) @(negedge clk_t);
  endtask

  // Monitor: every rx_valid pops the oldest expected frame and compares it.
  always @(negedge clk_t) begin
    exp_t e;
    if (rx_bus.rx_valid) begin
      check("rx_valid_single_cycle", {31'd0, prev_vld}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rx_valid: got out_data 0x%0h, expected no frame (t=%0t)",
                 rx_bus.out_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("out_data", {24'd0, rx_bus.out_data}, {24'd0, e.data});
        check("parity_err", {31'd0, rx_bus.parity_err}, {31'd0, e.perr});
        check("frame_err", {31'd0, rx_bus.frame_err}, {31'd0, e.ferr});
      end
    end
    prev_vld <= rx_bus.rx_valid;
  end

  // Length of the most recent busy window, in clk_t cycles.
  always @(negedge clk_t) begin
    if (rx_bus.busy) begin
      busy_cnt <= busy_cnt + 1;
    end else begin
      if (busy_cnt != 0) busy_len <= busy_cnt;
      busy_cnt <= 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [1:0] bd;
    logic       dn, sn, f, s0, s1;
    logic [1:0] pa;
    int         gap;

    #2 r_t = 1'b0;
    repeat (2) @(negedge clk_t);
    check("reset_out_data", {24'd0, rx_bus.out_data}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_bus.rx_valid}, 32'd0);
    check("reset_parity_err", {31'd0, rx_bus.parity_err}, 32'd0);
    check("reset_frame_err", {31'd0, rx_bus.frame_err}, 32'd0);
    check("reset_busy", {31'd0, rx_bus.busy}, 32'd0);
    @(negedge clk_t);
    r_t = 1'b1;
    repeat (10) @(negedge clk_t);

    // 8N1 at 9600: 0xA5, busy for roughly 9.5 bits.
    send_frame(8'hA5, 2'd3, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 2, 1'b0, -1);
    check("busy_idle_after_8n1", {31'd0, rx_bus.busy}, 32'd0);
    check("busy_len_8n1", {31'd0, (busy_len >= 9 * 64) && (busy_len <= 10 * 64)}, 32'd1);

    // 7E2 at 1200: correct then wrong parity bit.
    send_frame(8'h35, 2'd0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1, 1'b0, -1);
    send_frame(8'h35, 2'd0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1, 1'b0, -1);

    // 8O1 with bad stop, then a 3-bit break: nothing more until a new edge.
    send_frame(8'hFF, 2'd3, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 0, 1'b0, -1);
    in_data = 1'b0;
    repeat (3 * 64) @(negedge clk_t);
    check("busy_during_break", {31'd0, rx_bus.busy}, 32'd0);
    in_data = 1'b1;
    repeat (64) @(negedge clk_t);

    // Short glitches: false start, busy drops, no frame.
    in_data = 1'b0;
    repeat (24) @(negedge clk_t);
    in_data = 1'b1;
    check("busy_glitch_start", {31'd0, rx_bus.busy}, 32'd1);
    repeat (128) @(negedge clk_t);
    check("busy_glitch_end", {31'd0, rx_bus.busy}, 32'd0);
    bd_rate = 2'd0;
    in_data = 1'b0;
    repeat (48) @(negedge clk_t);
    in_data = 1'b1;
    repeat (600) @(negedge clk_t);
    check("busy_glitch_slow_end", {31'd0, rx_bus.busy}, 32'd0);

    // Back-to-back 8N1 frames.
    send_frame(8'h00, 2'd3, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 0, 1'b0, -1);
    send_frame(8'h81, 2'd3, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 2, 1'b0, -1);

    // Reset during data bit 4, then a clean frame.
    send_frame(8'h5A, 2'd3, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4);
    send_frame(8'h3C, 2'd3, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 2, 1'b0, -1);

    // Randomized frames with configuration scrambled mid-frame.
    for (int n = 0; n < 16; n++) begin
      d   = 8'($urandom);
      bd  = 2'(2 + $urandom_range(0, 1));
      dn  = 1'($urandom);
      sn  = 1'($urandom);
      pa  = 2'($urandom);
      f   = ($urandom_range(0, 3) == 0);
      s0  = ($urandom_range(0, 5) != 0);
      s1  = ($urandom_range(0, 5) != 0);
      gap = (!s0 || !s1) ? 2 : int'($urandom_range(0, 1));
      send_frame(d, bd, dn, sn, pa, f, s0, s1, gap, 1'b1, -1);
    end

    for (int w = 0; w < 5000 && exp_q.size() != 0; w++) @(negedge clk_t);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
